// File: rtl/alu_sequencer.sv
// Button-driven operand/op sequencer for the n-bit ALU.
// Collects A, B and op, holds them for the ALU, then captures result and flags.
module alu_sequencer #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         btn_next,
  input  logic         chain_en,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic [N-1:0] res_q,
  output logic [3:0]   flags_q,
  output logic         done,
  output logic         busy,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] r_q, r_d;
  logic [3:0]   f_q, f_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         s1_q, s2_q, s3_q;
  logic         press;

  // s1/s2 synchronize the raw button, s3 is the edge-detect history
  assign press = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    f_d     = f_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_GET_A: begin
        if (press) begin
          a_d     = data_in;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (press) begin
          b_d     = data_in;
          state_d = S_GET_OP;
        end
      end
      S_GET_OP: begin
        if (press) begin
          op_d    = data_in[1:0];
          cnt_d   = 4'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          r_d     = alu_result;
          f_d     = alu_flags;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (press) begin
          if (chain_en) begin
            a_d     = r_q;
            state_d = S_GET_B;
          end else begin
            state_d = S_GET_A;
          end
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      r_q     <= '0;
      f_q     <= '0;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      r_q     <= r_d;
      f_q     <= f_d;
      cnt_q   <= cnt_d;
      s1_q    <= btn_next;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_op  = op_q;
  assign res_q   = r_q;
  assign flags_q = f_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q == S_EXEC);
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU
// and a result scoreboard.
module tb_alu_sequencer;

  localparam int N      = 4;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] data_in;
  logic         btn_next;
  logic         chain_en;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic [N-1:0] alu_a, alu_b, res_q;
  logic [1:0]   alu_op;
  logic [3:0]   flags_q;
  logic         done, busy;
  logic [2:0]   state_o;

  int total = 0;
  int bad   = 0;
  int busy_run  = 0;
  int busy_last = 0;
  int cnt_a     = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .btn_next(btn_next), .chain_en(chain_en),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .res_q(res_q), .flags_q(flags_q), .done(done),
    .busy(busy), .state_o(state_o)
  );

  // returns {result, N, Z, C, V}; C on sub means no borrow
  function automatic logic [7:0] alu_f(
    input logic [3:0] a, input logic [3:0] b,
    input logic [1:0] op);
    logic [4:0] w;
    logic [3:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[3:0];
        c = w[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      2'd1: begin
        r = a - b;
        c = (a >= b);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r, r[3], (r == 4'd0), c, v};
  endfunction

  logic [7:0] alu_out;
  assign alu_out    = alu_f(alu_a, alu_b, alu_op);
  assign alu_result = alu_out[7:4];
  assign alu_flags  = alu_out[3:0];

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run <= 0;
    end else if (busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      busy_last <= busy_run;
      busy_run  <= 0;
    end
    if (state_o == 3'd0) cnt_a <= cnt_a + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    data_in  = d;
    btn_next = 1'b1;
    repeat (5) @(negedge clk);
    btn_next = 1'b0;
    data_in  = ~d;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n;
    n = 0;
    while (state_o !== s && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state_o), 32'(s));
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input string tag);
    sb.push_back(alu_f(a, b, op));
    press({2'b00, op});
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    check({tag, "_res"}, 32'(res_q), 32'(e[7:4]));
    check({tag, "_flags"}, 32'(flags_q), 32'(e[3:0]));
  endtask

  int snap;

  initial begin
    rst_n    = 1'b0;
    btn_next = 1'b0;
    data_in  = '0;
    chain_en = 1'b0;
    #3;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);
    check("rst_b", 32'(alu_b), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_res", 32'(res_q), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // add 3 + 4
    press(4'd3);
    check("add_stB", 32'(state_o), 32'd1);
    check("add_a", 32'(alu_a), 32'd3);
    press(4'd4);
    check("add_stOP", 32'(state_o), 32'd2);
    check("add_b", 32'(alu_b), 32'd4);
    run_op(4'd3, 4'd4, 2'd0, "add");
    wait_done("add");
    check("add_st", 32'(state_o), 32'd4);
    check("add_opreg", 32'(alu_op), 32'd0);
    check("exec_len", 32'(busy_last), 32'(SETTLE));

    // sub 2 - 5 with borrow
    press(4'd0);
    check("sub_toA", 32'(state_o), 32'd0);
    press(4'd2);
    press(4'd5);
    run_op(4'd2, 4'd5, 2'd1, "sub");
    wait_done("sub");
    check("sub_opreg", 32'(alu_op), 32'd1);

    // chain: 3 + 4 = 7, then 7 + 1 = 8
    press(4'd0);
    press(4'd3);
    press(4'd4);
    run_op(4'd3, 4'd4, 2'd0, "ch1");
    wait_done("ch1");
    chain_en = 1'b1;
    snap = cnt_a;
    press(4'd9);
    check("ch_stB", 32'(state_o), 32'd1);
    check("ch_a", 32'(alu_a), 32'd7);
    press(4'd1);
    run_op(4'd7, 4'd1, 2'd0, "ch2");
    wait_done("ch2");
    check("ch_noA", 32'(cnt_a), 32'(snap));
    chain_en = 1'b0;

    // AND giving zero
    press(4'd0);
    press(4'hA);
    press(4'h5);
    run_op(4'hA, 4'h5, 2'd2, "and");
    wait_done("and");

    // press arriving during EXEC is ignored
    press(4'd0);
    press(4'd6);
    press(4'd3);
    sb.push_back(alu_f(4'd6, 4'd3, 2'd0));
    @(negedge clk);
    data_in  = 4'd0;
    btn_next = 1'b1;
    wait_state(3'd3, "ign_exec");
    btn_next = 1'b0;
    @(negedge clk);
    btn_next = 1'b1;
    data_in  = 4'hE;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (5) @(negedge clk);
    wait_done("ign");
    check("ign_st", 32'(state_o), 32'd4);
    check("ign_a", 32'(alu_a), 32'd6);
    check("ign_op", 32'(alu_op), 32'd0);

    // held button loads A only once
    press(4'd0);
    @(negedge clk);
    data_in  = 4'hC;
    btn_next = 1'b1;
    repeat (20) @(negedge clk);
    btn_next = 1'b0;
    data_in  = 4'h1;
    repeat (5) @(negedge clk);
    check("hold_st", 32'(state_o), 32'd1);
    check("hold_a", 32'(alu_a), 32'hC);

    // async reset in the middle of EXEC
    press(4'd2);
    @(negedge clk);
    data_in  = 4'd0;
    btn_next = 1'b1;
    wait_state(3'd3, "ar_exec");
    rst_n = 1'b0;
    #1;
    check("ar_st", 32'(state_o), 32'd0);
    check("ar_a", 32'(alu_a), 32'd0);
    check("ar_b", 32'(alu_b), 32'd0);
    check("ar_res", 32'(res_q), 32'd0);
    check("ar_flags", 32'(flags_q), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    btn_next = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd5);
    check("ar_rel_st", 32'(state_o), 32'd1);
    check("ar_rel_a", 32'(alu_a), 32'd5);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
